// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared constants and state encoding for the wide ALU sequencer
//
// Purpose: state encoding, nibble width, mode constants and the subtract
// opcode shared by wide_alu_seq and its wrapper.
// Ports: none (package).

package alu_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  localparam logic M_LOGIC = 1'b1;
  localparam logic M_ARITH = 1'b0;

  localparam logic [3:0] OP_SUB = 4'b0110;

endpackage

// File: rtl/wide_alu_seq.sv
// rtl/wide_alu_seq.sv - nibble-serial sequencer driving an external 4-bit ALU
//
// Purpose: performs a W-bit ALU operation by stepping an external 4-bit ALU
// over NIBBLES slices, LSB first, one slice per clock, chaining the carry.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request, accepted in IDLE or DONE
//   op_a, op_b               W-bit operands
//   op_s, op_m, op_cin       function select, mode (1 = logic), carry in
//   alu_a, alu_b             nibble operands to the ALU
//   alu_s, alu_m, alu_cin    function, mode and carry to the ALU
//   alu_f, alu_cout, alu_eqv combinational ALU results
//   busy, done               RUN indicator, one-cycle completion pulse
//   result, carry_out,
//   equal, zero              final word and flags, held until next start

module wide_alu_seq
  import alu_defs::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NIB_W*NIBBLES-1:0]   op_a,
  input  logic [NIB_W*NIBBLES-1:0]   op_b,
  input  logic [3:0]                 op_s,
  input  logic                       op_m,
  input  logic                       op_cin,
  output logic [NIB_W-1:0]           alu_a,
  output logic [NIB_W-1:0]           alu_b,
  output logic [3:0]                 alu_s,
  output logic                       alu_m,
  output logic                       alu_cin,
  input  logic [NIB_W-1:0]           alu_f,
  input  logic                       alu_cout,
  input  logic                       alu_eqv,
  output logic                       busy,
  output logic                       done,
  output logic [NIB_W*NIBBLES-1:0]   result,
  output logic                       carry_out,
  output logic                       equal,
  output logic                       zero
);

  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [NIB_W-1:0] a_q   [NIBBLES];
  logic [NIB_W-1:0] b_q   [NIBBLES];
  logic [NIB_W-1:0] res_q [NIBBLES];
  logic [3:0]       s_q;
  logic             m_q;
  logic             cin_q;
  logic             chain_q;
  logic             carry_q;
  logic             eq_q;
  logic             zero_q;

  logic accept;
  logic last_nib;
  logic chain_d;
  logic zero_d;

  // start is ignored while RUN is in progress; no queuing.
  assign accept   = start && (state_q != S_RUN);
  assign last_nib = (k_q == K_LAST);

  // Subtract in arithmetic mode reports borrow on cout, so the chain bit
  // is inverted to keep "cin = 1 means +1" for the next slice.
  assign chain_d = ((s_q == OP_SUB) && (m_q == M_ARITH)) ? ~alu_cout : alu_cout;

  // Zero test of the word as it will look after the current slice lands.
  always_comb begin
    zero_d = (alu_f == '0);
    for (int i = 0; i < NIBBLES; i++) begin
      if (KW'(i) != k_q && res_q[i] != '0) begin
        zero_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        alu_a   = a_q[k_q];
        alu_b   = b_q[k_q];
        alu_cin = (k_q == '0) ? cin_q : chain_q;
        if (last_nib) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_s     = s_q;
  assign alu_m     = m_q;
  assign carry_out = carry_q;
  assign equal     = eq_q;
  assign zero      = zero_q;

  for (genvar g = 0; g < NIBBLES; g++) begin : g_result
    assign result[g*NIB_W +: NIB_W] = res_q[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      chain_q <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      zero_q  <= 1'b0;
      for (int i = 0; i < NIBBLES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        k_q     <= '0;
        s_q     <= op_s;
        m_q     <= op_m;
        cin_q   <= op_cin;
        chain_q <= 1'b0;
        carry_q <= 1'b0;
        eq_q    <= 1'b1;
        zero_q  <= 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
          a_q[i]   <= op_a[i*NIB_W +: NIB_W];
          b_q[i]   <= op_b[i*NIB_W +: NIB_W];
          res_q[i] <= '0;
        end
      end else if (state_q == S_RUN) begin
        res_q[k_q] <= alu_f;
        eq_q       <= eq_q & alu_eqv;
        chain_q    <= chain_d;
        if (last_nib) begin
          k_q     <= '0;
          carry_q <= alu_cout;
          zero_q  <= zero_d;
        end else begin
          k_q <= k_q + KW'(1);
        end
      end
    end
  end

endmodule

// File: doc/wide_alu_seq.md
WIDE_ALU_SEQ -- requirements
Module: wide_alu_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NIBBLES SHALL default to 4 and sets the number of 4-bit slices; W = 4*NIBBLES.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request; accepted only in IDLE or DONE.
REQ-006 op_a, op_b  in  W  operands.
REQ-007 op_s  in  4  ALU function select.
REQ-008 op_m  in  1  mode: 1 = logic, 0 = arithmetic.
REQ-009 op_cin  in  1  carry into nibble 0; 1 means +1.
REQ-010 alu_a, alu_b  out  4  nibble operands driven to the 4-bit ALU.
REQ-011 alu_s  out  4, alu_m  out  1, alu_cin  out  1  function, mode and carry driven to the ALU.
REQ-012 alu_f  in  4, alu_cout  in  1, alu_eqv  in  1  combinational ALU results, valid in the same cycle.
REQ-013 busy  out  1  high in RUN.
REQ-014 done  out  1  high for exactly one cycle, in DONE.
REQ-015 result  out  W; carry_out  out  1; equal  out  1; zero  out  1  final word and flags.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 Transitions: IDLE->RUN on start; RUN->DONE after nibble NIBBLES-1 is captured; DONE->RUN on start, else DONE->IDLE.
REQ-018 On start acceptance, op_a, op_b, op_s, op_m and op_cin SHALL be latched; input changes during RUN SHALL be ignored.
REQ-019 start while in RUN SHALL be ignored; no queuing.
REQ-020 In RUN, nibble index k SHALL go 0..NIBBLES-1, one per cycle, LSB first; alu_a/alu_b SHALL be the latched nibble k; alu_s/alu_m SHALL be the latched values.
REQ-021 alu_cin SHALL be op_cin for k=0; for k>0 it SHALL be the chain bit registered from nibble k-1.
REQ-022 The chain bit SHALL be ~alu_cout when the latched op_s=0110 and op_m=0 (borrow convention); otherwise it SHALL be alu_cout.
REQ-023 At each RUN edge, alu_f SHALL be written to result[4k+3:4k].
REQ-024 At each RUN edge, an equality accumulator SHALL be ANDed with alu_eqv; the accumulator is preset to 1 on acceptance.
REQ-025 Outside RUN, alu_a, alu_b and alu_cin SHALL be 0; alu_s and alu_m SHALL hold their latched values.
REQ-026 Latency: if start is accepted at edge E0, nibbles are computed between E0 and E(NIBBLES), and done=1 from E(NIBBLES) to E(NIBBLES+1).
REQ-027 In DONE: carry_out SHALL be the raw alu_cout of the last nibble; equal SHALL be the accumulator; zero SHALL be (result==0).
REQ-028 result and all flags SHALL hold their value until the next accepted start.
REQ-029 In logic mode, carry chaining SHALL still occur exactly as in REQ-021/REQ-022; the ALU ignores cin in that mode.
REQ-030 A start in the DONE cycle SHALL be accepted; done SHALL then drop the next cycle, giving back-to-back operations with no idle gap.

Reset
REQ-031 rst SHALL force IDLE, k=0, result=0, carry_out=0, equal=0, zero=0, busy=0 and done=0, and clear the latched operands.
REQ-032 Reset during RUN SHALL abort the operation with no done pulse; reset has priority over start.

Structure
REQ-033 A shared package/header alu_defs SHALL hold the state encodings, NIB_W=4, the mode constants M_LOGIC=1 and M_ARITH=0, and the subtract opcode 0110.
REQ-034 The block SHALL contain no sub-module; the 4-bit ALU is instantiated beside it in the wrapper wide_alu_top and connected through the alu_* ports.

Verification
REQ-035 Add 0x00FF+0x0001, s=1001, m=0, cin=0 -> result=0x0100, carry_out=0, done exactly 4 cycles after the start edge.
REQ-036 Add 0xFFFF+0x0001 -> result=0x0000, carry_out=1, zero=1.
REQ-037 Subtract 0x1000-0x0001, s=0110, m=0, cin=1 -> result=0x0FFF, carry_out=0; alu_cin=0 on nibbles 1..3.
REQ-038 XOR (s=0110, m=1) of 0xA5A5 and 0x5A5A -> result=0xFFFF, equal=0; repeated with 0x1234 and 0x1234 -> result=0x0000, equal=1, zero=1.
REQ-039 Start pulsed again during RUN, and op_a changed mid-run -> ignored, result matches the first operands; then reset at the second RUN cycle -> IDLE, all outputs 0, no done.
REQ-040 Start held in the DONE cycle -> second operation accepted, busy re-asserts the next cycle, and two done pulses occur 5 cycles apart.
